// File: rtl/gear_input_conditioner.sv
// Gear input conditioner: sync, debounce and plausibility checks
// for the landing gear controller sensor and lever inputs.
module gear_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TRANSIT_CYCLES  = 1024
) (
  input  logic Clock,
  input  logic Clear,
  input  logic RawGearIsDown,
  input  logic RawGearIsUp,
  input  logic RawPlaneOnGround,
  input  logic RawLever,
  output logic GearIsDown,
  output logic GearIsUp,
  output logic PlaneOnGround,
  output logic Lever,
  output logic Changed,
  output logic SensorFault,
  output logic TransitFault
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TRANSIT_CYCLES + 1);
  localparam logic [CW-1:0] DLAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TRANSIT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TRANSIT_CYCLES - 1);
  // Bit order: down, up, on-ground, lever; safe state is on ground.
  localparam logic [3:0] SAFE = 4'b1010;

  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    level;
  logic [3:0]    upd;
  logic [CW-1:0] cnt [4];
  logic [TW-1:0] tcnt;
  logic          in_transit;
  logic          changed;
  logic          sensor_fault;
  logic          transit_fault;

  assign raw = {RawGearIsDown, RawGearIsUp,
                RawPlaneOnGround, RawLever};

  assign in_transit = !level[3] && !level[2];

  // Channels whose mismatch run completes on this edge.
  always_comb begin
    upd = '0;
    for (int i = 0; i < 4; i++) begin
      upd[i] = (sync2[i] != level[i]) && (cnt[i] == DLAST);
    end
  end

  // Two-flop synchronizer per channel.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      sync1 <= SAFE;
      sync2 <= SAFE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce counters and output levels.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      level <= SAFE;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Single pulse for any set of simultaneous level updates.
  always_ff @(posedge Clock) begin
    if (Clear) changed <= 1'b0;
    else       changed <= |upd;
  end

  // Sticky conflict flag on both limit switches.
  always_ff @(posedge Clock) begin
    if (Clear) sensor_fault <= 1'b0;
    else       sensor_fault <= sensor_fault | (level[3] & level[2]);
  end

  // Saturating transit timer, zeroed by either limit switch.
  always_ff @(posedge Clock) begin
    if (Clear)            tcnt <= '0;
    else if (!in_transit) tcnt <= '0;
    else if (tcnt != TMAX) tcnt <= tcnt + TW'(1);
  end

  // Sticky timeout flag, set as the timer reaches its limit.
  always_ff @(posedge Clock) begin
    if (Clear)
      transit_fault <= 1'b0;
    else if (in_transit && tcnt == TLAST)
      transit_fault <= 1'b1;
  end

  assign GearIsDown    = level[3];
  assign GearIsUp      = level[2];
  assign PlaneOnGround = level[1];
  assign Lever         = level[0];
  assign Changed       = changed;
  assign SensorFault   = sensor_fault;
  assign TransitFault  = transit_fault;

endmodule

// File: tb/tb_gear_input_conditioner.sv
// Directed bench for gear_input_conditioner: vector table plus a
// hand-written clear-during-debounce sequence.
module tb_gear_input_conditioner;

  logic Clock;
  logic Clear;
  logic RawGearIsDown, RawGearIsUp, RawPlaneOnGround, RawLever;
  logic GearIsDown, GearIsUp, PlaneOnGround, Lever;
  logic Changed, SensorFault, TransitFault;

  int total = 0;
  int bad   = 0;

  gear_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .TRANSIT_CYCLES (16)
  ) dut (
    .Clock           (Clock),
    .Clear           (Clear),
    .RawGearIsDown   (RawGearIsDown),
    .RawGearIsUp     (RawGearIsUp),
    .RawPlaneOnGround(RawPlaneOnGround),
    .RawLever        (RawLever),
    .GearIsDown      (GearIsDown),
    .GearIsUp        (GearIsUp),
    .PlaneOnGround   (PlaneOnGround),
    .Lever           (Lever),
    .Changed         (Changed),
    .SensorFault     (SensorFault),
    .TransitFault    (TransitFault)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic       clr;
    logic [3:0] raw;
    int         n;
    logic [3:0] out;
    int         pulses;
    logic       sf;
    logic       tf;
  } vec_t;

  vec_t tbl[$];
  int   pc;

  function automatic vec_t mk(logic c, logic [3:0] r, int n,
                              logic [3:0] o, int p,
                              logic sf, logic tf);
    vec_t v;
    v.clr = c; v.raw = r; v.n = n; v.out = o;
    v.pulses = p; v.sf = sf; v.tf = tf;
    return v;
  endfunction

  function automatic logic [3:0] outs();
    return {GearIsDown, GearIsUp, PlaneOnGround, Lever};
  endfunction

  task automatic chk(string nm, int idx,
                     logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%0h want=%0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(logic c, logic [3:0] r);
    Clear = c;
    {RawGearIsDown, RawGearIsUp, RawPlaneOnGround, RawLever} = r;
  endtask

  task automatic step(int n);
    for (int e = 0; e < n; e++) begin
      @(posedge Clock);
      #1;
      if (Changed === 1'b1) pc++;
    end
  endtask

  initial begin
    int k;
    drive(1'b1, 4'b1010);
    // clr raw n out pulses sf tf
    tbl.push_back(mk(1, 4'b1010,  2, 4'b1010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 20, 4'b1010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1011,  5, 4'b1010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1011,  1, 4'b1011, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1011,  4, 4'b1011, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 10, 4'b1010, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1000,  3, 4'b1010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 10, 4'b1010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1000,  4, 4'b1010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010,  2, 4'b1000, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1010,  8, 4'b1010, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1110,  6, 4'b1110, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1110,  1, 4'b1110, 0, 1, 0));
    tbl.push_back(mk(0, 4'b1110,  3, 4'b1110, 0, 1, 0));
    tbl.push_back(mk(0, 4'b1010, 10, 4'b1010, 1, 1, 0));
    tbl.push_back(mk(0, 4'b1011,  6, 4'b1011, 1, 1, 0));
    tbl.push_back(mk(1, 4'b1011,  1, 4'b1010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010,  8, 4'b1010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010,  6, 4'b0010, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 15, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010,  1, 4'b0010, 0, 0, 1));
    tbl.push_back(mk(0, 4'b1010, 10, 4'b1010, 1, 0, 1));
    tbl.push_back(mk(1, 4'b1010,  1, 4'b1010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 12, 4'b0010, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0110,  6, 4'b0110, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0110, 20, 4'b0110, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010,  6, 4'b1010, 1, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].raw);
      pc = 0;
      step(tbl[i].n);
      chk("outs",   i, 32'(outs()),        32'(tbl[i].out));
      chk("pulses", i, 32'(pc),            32'(tbl[i].pulses));
      chk("sfault", i, 32'(SensorFault),   32'(tbl[i].sf));
      chk("tfault", i, 32'(TransitFault),  32'(tbl[i].tf));
    end

    // Clear lands on the 4th edge of a pending lever debounce.
    drive(1'b0, 4'b1011);
    pc = 0;
    step(3);
    drive(1'b1, 4'b1011);
    step(1);
    chk("clr_mid_outs",  0, 32'(outs()), 32'(4'b1010));
    drive(1'b0, 4'b1011);
    k = 0;
    for (int e = 1; e <= 20; e++) begin
      step(1);
      if (k == 0 && Lever === 1'b1) k = e;
    end
    chk("clr_mid_lat",    0, 32'(k),      32'(6));
    chk("clr_mid_pulses", 0, 32'(pc),     32'(1));
    chk("clr_mid_final",  0, 32'(outs()), 32'(4'b1011));
    chk("clr_mid_sf",     0, 32'(SensorFault), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
